// File: rtl/sw_debounce.sv
//=============================================================================
// Module      : sw_debounce
// Description : 16-bit switch debouncer: 2-flop sync, tick-sampled counters,
//               sticky change flag; edge pulses with SW_DEBOUNCE_EDGE_EN.
// Revision    : 1.0 - initial release
//=============================================================================
`default_nettype none

module sw_debounce #(
   parameter int TICK_DIV   = 100000,
   parameter int DB_SAMPLES = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [15:0] sw_i,
   output logic [15:0] sw_o,
   input  logic        chg_clr,
   output logic        chg_o
`ifdef SW_DEBOUNCE_EDGE_EN
   ,
   output logic [15:0] sw_rise,
   output logic [15:0] sw_fall
`endif
);

   localparam int               c_PW        = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [c_PW-1:0]  c_TICK_LAST = c_PW'(TICK_DIV - 1);
   localparam logic [3:0]       c_CNT_LAST  = 4'(DB_SAMPLES - 1);

   logic [15:0]     r_sync1;
   logic [15:0]     r_sync2;
   logic [15:0]     r_sw;
   logic            r_chg;
   logic [c_PW-1:0] r_presc;
   logic            w_tick;
   logic [15:0]     w_diff;
   logic [15:0]     w_flip;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_sync1 <= '0;
         r_sync2 <= '0;
      end else begin
         r_sync1 <= sw_i;
         r_sync2 <= r_sync1;
      end
   end

   // With TICK_DIV=1 the counter stays at 0 and the tick is permanently high.
   assign w_tick = (r_presc == c_TICK_LAST);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_presc <= '0;
      end else if (w_tick) begin
         r_presc <= '0;
      end else begin
         r_presc <= r_presc + c_PW'(1);
      end
   end

   assign w_diff = r_sync2 ^ r_sw;

   genvar i;
   generate
      for (i = 0; i < 16; i++) begin : g_bit
         logic [3:0] r_cnt;

         assign w_flip[i] = w_tick & w_diff[i] & (r_cnt == c_CNT_LAST);

         // Any tick that agrees with the current output restarts qualification.
         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               r_cnt <= 4'd0;
            end else if (w_tick) begin
               if (w_diff[i] && (r_cnt != c_CNT_LAST)) begin
                  r_cnt <= r_cnt + 4'd1;
               end else begin
                  r_cnt <= 4'd0;
               end
            end
         end
      end
   endgenerate

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_sw  <= '0;
         r_chg <= 1'b0;
      end else begin
         r_sw <= r_sw ^ w_flip;
         if (|w_flip) begin
            r_chg <= 1'b1;
         end else if (chg_clr) begin
            r_chg <= 1'b0;
         end
      end
   end

   assign sw_o  = r_sw;
   assign chg_o = r_chg;

`ifdef SW_DEBOUNCE_EDGE_EN
   logic [15:0] r_rise;
   logic [15:0] r_fall;

   // Registered alongside r_sw so the pulse coincides with the new level.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_rise <= '0;
         r_fall <= '0;
      end else begin
         r_rise <= w_flip & r_sync2;
         r_fall <= w_flip & ~r_sync2;
      end
   end

   assign sw_rise = r_rise;
   assign sw_fall = r_fall;
`endif

endmodule

`default_nettype wire

// File: tb/tb_sw_debounce.sv
//=============================================================================
// Module      : tb_sw_debounce
// Description : Self-checking bench for sw_debounce (TICK_DIV=4, DB_SAMPLES=3).
// Revision    : 1.0 - initial release
//=============================================================================
`default_nettype none

module tb_sw_debounce;

   localparam int c_TD = 4;
   localparam int c_DB = 3;

   logic        clk;
   logic        rst;
   logic [15:0] sw_i;
   logic        chg_clr;
   wire  [15:0] sw_o;
   wire         chg_o;
`ifdef SW_DEBOUNCE_EDGE_EN
   wire  [15:0] sw_rise;
   wire  [15:0] sw_fall;
`endif

   sw_debounce #(.TICK_DIV(c_TD), .DB_SAMPLES(c_DB)) dut (
      .clk     (clk),
      .rst     (rst),
      .sw_i    (sw_i),
      .sw_o    (sw_o),
      .chg_clr (chg_clr),
      .chg_o   (chg_o)
`ifdef SW_DEBOUNCE_EDGE_EN
      ,
      .sw_rise (sw_rise),
      .sw_fall (sw_fall)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;

   // Reference model: counts consecutive disagreeing ticks per switch.
   logic [15:0] m_s1, m_s2, m_sw, m_rise, m_fall;
   logic        m_chg;
   int          m_n;
   int          m_run [16];

   task automatic model_reset();
      m_s1 = '0; m_s2 = '0; m_sw = '0; m_rise = '0; m_fall = '0;
      m_chg = 1'b0; m_n = 0;
      for (int k = 0; k < 16; k++) m_run[k] = 0;
   endtask

   task automatic model_update();
      logic        tick;
      logic [15:0] flip;
      if (rst) begin
         model_reset();
      end else begin
         tick = ((m_n % c_TD) == c_TD - 1);
         m_n++;
         flip = '0;
         if (tick) begin
            for (int k = 0; k < 16; k++) begin
               if (m_s2[k] != m_sw[k]) begin
                  m_run[k]++;
                  if (m_run[k] == c_DB) begin
                     flip[k]  = 1'b1;
                     m_run[k] = 0;
                  end
               end else begin
                  m_run[k] = 0;
               end
            end
         end
         m_rise = flip & ~m_sw;
         m_fall = flip & m_sw;
         m_sw   = m_sw ^ flip;
         if (flip != 16'h0) m_chg = 1'b1;
         else if (chg_clr)  m_chg = 1'b0;
         m_s2 = m_s1;
         m_s1 = sw_i;
      end
   endtask

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
      end
   endtask

   task automatic step(input int n);
      for (int c = 0; c < n; c++) begin
         @(posedge clk);
         model_update();
         @(negedge clk);
         chk("model_sw_o", sw_o, m_sw);
         chk("model_chg_o", {15'h0, chg_o}, {15'h0, m_chg});
`ifdef SW_DEBOUNCE_EDGE_EN
         chk("model_sw_rise", sw_rise, m_rise);
         chk("model_sw_fall", sw_fall, m_fall);
`endif
      end
   endtask

   // Asserts reset between edges and checks the asynchronous clear; leaves rst high.
   task automatic reset_on();
      rst = 1'b1;
      #1;
      chk("rst_sw_o", sw_o, 16'h0000);
      chk("rst_chg_o", {15'h0, chg_o}, 16'h0000);
`ifdef SW_DEBOUNCE_EDGE_EN
      chk("rst_sw_rise", sw_rise, 16'h0000);
      chk("rst_sw_fall", sw_fall, 16'h0000);
`endif
      model_reset();
      step(2);
   endtask

   initial begin
      int          trans;
      logic        prev;
      logic [15:0] fall_acc;
      rst = 1'b0; sw_i = '0; chg_clr = 1'b0;
      model_reset();
      @(negedge clk);

      // Glitch on bit 7 shorter than a tick period
      reset_on();
      rst = 1'b0;
      step(3);
      sw_i[7] = 1'b1;
      step(2);
      sw_i[7] = 1'b0;
      step(30);
      chk("glitch_sw_o", sw_o, 16'h0000);
      chk("glitch_chg_o", {15'h0, chg_o}, 16'h0000);

      // Clean press held from reset release: flips on the 12th edge
      reset_on();
      sw_i = 16'h0001;
      rst  = 1'b0;
      step(11);
      chk("press_early_sw_o", sw_o, 16'h0000);
      step(1);
      chk("press_sw_o", sw_o, 16'h0001);
      chk("press_chg_o", {15'h0, chg_o}, 16'h0001);
`ifdef SW_DEBOUNCE_EDGE_EN
      chk("press_sw_rise", sw_rise, 16'h0001);
`endif
      step(1);
`ifdef SW_DEBOUNCE_EDGE_EN
      chk("press_rise_end", sw_rise, 16'h0000);
`endif
      chk("press_hold_sw_o", sw_o, 16'h0001);

      // Bounce on bit 3: 1,0 for a tick each, then held
      sw_i[3] = 1'b1; step(4);
      sw_i[3] = 1'b0; step(4);
      sw_i[3] = 1'b1; step(8);
      chk("bounce_early_sw_o", sw_o, 16'h0001);
      trans = 0;
      prev  = sw_o[3];
      for (int c = 0; c < 30; c++) begin
         step(1);
`ifdef SW_DEBOUNCE_EDGE_EN
         if (sw_rise[3]) trans++;
`else
         if (sw_o[3] != prev) trans++;
         prev = sw_o[3];
`endif
      end
      chk("bounce_sw_o", sw_o, 16'h0009);
      chk("bounce_single_edge", 16'(trans), 16'd1);

      // chg_clr on the same edge as a flip of bit 2: set wins
      chg_clr = 1'b1;
      step(1);
      sw_i[2] = 1'b1;
      for (int c = 0; c < 40; c++) begin
         step(1);
         if (sw_o[2]) break;
      end
      chk("simul_sw_o", sw_o, 16'h000D);
      chk("simul_chg_o", {15'h0, chg_o}, 16'h0001);
      step(1);
      chk("simul_clr_chg_o", {15'h0, chg_o}, 16'h0000);
      chg_clr = 1'b0;

      // Multi-bit: eight bits rise together, no falls
      sw_i = 16'h0000;
      step(30);
      chg_clr = 1'b1; step(1); chg_clr = 1'b0;
      chk("multi_pre_sw_o", sw_o, 16'h0000);
      chk("multi_pre_chg_o", {15'h0, chg_o}, 16'h0000);
      sw_i     = 16'hA5A5;
      fall_acc = '0;
      for (int c = 0; c < 30; c++) begin
         step(1);
`ifdef SW_DEBOUNCE_EDGE_EN
         fall_acc = fall_acc | sw_fall;
`endif
         if (sw_o != 16'h0000) break;
      end
      chk("multi_sw_o", sw_o, 16'hA5A5);
      chk("multi_chg_o", {15'h0, chg_o}, 16'h0001);
`ifdef SW_DEBOUNCE_EDGE_EN
      chk("multi_sw_rise", sw_rise, 16'hA5A5);
      chk("multi_no_fall", fall_acc, 16'h0000);
`endif

      // Reset after two qualifying ticks discards the partial count
      reset_on();
      sw_i = 16'hFFFF;
      rst  = 1'b0;
      step(10);
      chk("midrst_partial_sw_o", sw_o, 16'h0000);
      reset_on();
      rst = 1'b0;
      step(11);
      chk("midrst_early_sw_o", sw_o, 16'h0000);
      step(1);
      chk("midrst_sw_o", sw_o, 16'hFFFF);
      chk("midrst_chg_o", {15'h0, chg_o}, 16'h0001);

      // Random single-bit toggles with random chg_clr, checked every cycle
      for (int c = 0; c < 3000; c++) begin
         if ($urandom_range(0, 15) == 0) begin
            int b;
            b = $urandom_range(0, 15);
            sw_i[b] = ~sw_i[b];
         end
         chg_clr = ($urandom_range(0, 5) == 0);
         step(1);
      end
      chg_clr = 1'b0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/sw_debounce.md
SW_DEBOUNCE -- requirements
Module: sw_debounce

Interface
REQ-001 The block SHALL have parameter TICK_DIV, default 100000, meaning clk cycles per debounce sample tick; legal range 1..2^20.
REQ-002 The block SHALL have parameter DB_SAMPLES, default 8, meaning consecutive differing ticks required to accept a change; legal range 2..15.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock (Clk_CPU domain).
REQ-004 The block SHALL have port rst, input, 1 bit: the reset, asynchronous and active-high.
REQ-005 The block SHALL have port sw_i, input, 16 bits: the raw asynchronous board switches.
REQ-006 The block SHALL have port sw_o, output, 16 bits: the debounced switch levels, which feed MIO_BUS and the display select.
REQ-007 The block SHALL have port chg_clr, input, 1 bit: clears the sticky change flag.
REQ-008 The block SHALL have port chg_o, output, 1 bit: sticky flag, set when any sw_o bit changed.
REQ-009 The block SHALL have port sw_rise, output, 16 bits: per-bit rising-edge pulse; present only under the configuration macro.
REQ-010 The block SHALL have port sw_fall, output, 16 bits: per-bit falling-edge pulse; present only under the configuration macro.

Function
REQ-011 Each sw_i bit SHALL pass through a 2-flop synchronizer; the second-stage value is called s[i].
REQ-012 A prescaler SHALL count 0..TICK_DIV-1 and wrap to 0, with tick high for one cycle when the count equals TICK_DIV-1; for TICK_DIV=1, tick SHALL be high every cycle.
REQ-013 Each bit SHALL have a counter cnt[i], 4 bits wide, which changes only in tick cycles.
REQ-014 In a tick cycle where s[i]==sw_o[i], cnt[i] SHALL be set to 0, so any bounce restarts the qualification.
REQ-015 In a tick cycle where s[i]!=sw_o[i] and cnt[i]<DB_SAMPLES-1, cnt[i] SHALL increment.
REQ-016 In a tick cycle where s[i]!=sw_o[i] and cnt[i]==DB_SAMPLES-1, sw_o[i] SHALL take s[i] at that clock edge and cnt[i] SHALL return to 0.
REQ-017 Bits SHALL be independent; several bits may flip on the same edge.
REQ-018 chg_o SHALL go to 1 on the edge where any sw_o bit flips, and SHALL go to 0 on an edge with chg_clr=1 and no flip; if a flip and chg_clr=1 occur on the same edge, set SHALL win.
REQ-019 Non-tick cycles SHALL leave cnt and sw_o unchanged.
REQ-020 The minimum latency from a stable s[i] change to sw_o[i] SHALL be DB_SAMPLES ticks (plus 2 synchronizer cycles from sw_i).

Reset
REQ-021 While rst=1, the synchronizer flops, sw_o, cnt, the prescaler, chg_o, sw_rise and sw_fall SHALL all be 0, asynchronously.
REQ-022 Reset asserted mid-qualification SHALL discard partial counts; after release, qualification SHALL restart from 0 with the prescaler at 0.
REQ-023 After reset release, a switch held high SHALL appear on sw_o only after full qualification, and chg_o and sw_rise SHALL then fire once.

Configuration
REQ-024 With macro SW_DEBOUNCE_EDGE_EN defined, sw_rise[i] (or sw_fall[i]) SHALL be high for exactly the one cycle in which sw_o[i] first shows its new value 1 (or 0), and both SHALL be registered.
REQ-025 Without SW_DEBOUNCE_EDGE_EN, the sw_rise and sw_fall ports and their logic SHALL be absent; all other behaviour SHALL be identical.

Verification (TICK_DIV=4, DB_SAMPLES=3)
REQ-026 Clean press: sw_i=16'h0001 held from reset release -> sw_o=16'h0001 after 3 ticks (at most 2+12 clks), chg_o=1, and sw_rise=16'h0001 for 1 clk.
REQ-027 Bounce: sw_i[3] toggles 1,0,1 with each level held for 1 tick, then held at 1 -> no sw_o change until 3 consecutive ticks at 1, then a single rise pulse.
REQ-028 Glitch: sw_i[7] pulses high for 2 clks -> sw_o remains 16'h0000 and chg_o remains 0.
REQ-029 Simultaneous: chg_clr=1 on the same edge as an sw_o[2] flip -> chg_o=1; chg_clr=1 on a later cycle -> chg_o=0.
REQ-030 Reset mid-operation: rst pulsed after 2 qualifying ticks of 16'hFFFF -> outputs are 0, and a full 3 ticks are needed again after release.
REQ-031 Multi-bit: sw_i 16'h0000->16'hA5A5 -> all eight bits flip on the same edge, and sw_fall stays 0.
